mcs4_run_ctrl: RTL and testbench

Run/boot controller for the MCS-4 core (i4004 CPU, i4001 ROM, i4002 RAM).
- Generates the two-phase clock enables `clken_1`/`clken_2`.
- Holds and releases CPU reset.
- Streams a host-supplied program image into the ROM write port.
- Sequences CPU execution as halt, free-run or single instruction cycle on host command.
- Sits between the PYNQ host interface and the MCS-4 system.

---
 rtl/mcs4_run_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_mcs4_run_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_run_ctrl.sv
// Run/boot controller for the MCS-4 core: two-phase clock enables, CPU reset, ROM image
// loading and halt/run/step sequencing. Define MCS4_CYCLE_CNT_EN to add the icycle_cnt output.
module mcs4_run_ctrl #(
    parameter int CLK_DIV     = 8,
    parameter int ROM_ADDR_W  = 8,
    parameter int RST_CYCLES  = 16,
    parameter int STEP_PHASES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_err,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [7:0]            load_data,
    input  logic                  load_last,
    output logic                  rom_we,
    output logic [ROM_ADDR_W-1:0] rom_waddr,
    output logic [7:0]            rom_wdata,
    output logic                  cpu_rst,
    output logic                  clken_1,
    output logic                  clken_2,
    input  logic                  sync,
    output logic [2:0]            state,
    output logic                  busy
`ifdef MCS4_CYCLE_CNT_EN
    ,
    output logic [31:0]           icycle_cnt
`endif
);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int STEP_W = $clog2(STEP_PHASES + 1);

    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]      DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [STEP_W-1:0]     STEP_DONE = STEP_W'(STEP_PHASES);
    localparam logic [ROM_ADDR_W-1:0] ADDR_LAST = '1;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    typedef enum logic [2:0] {
        S_HALT     = 3'd0,
        S_LOAD     = 3'd1,
        S_RST_HOLD = 3'd2,
        S_RUN      = 3'd3,
        S_STEP     = 3'd4
    } state_t;

    state_t                cur, nxt;
    logic [DIV_W-1:0]      div_cnt, div_nxt;
    logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
    logic [STEP_W-1:0]     step_cnt, step_nxt;
    logic [ROM_ADDR_W-1:0] load_addr, addr_nxt;
    logic                  rst_pending, pend_nxt;
    logic                  target_step, target_nxt;
    logic                  halt_req, halt_nxt;
    logic                  halt_now;
    logic                  we_nxt, err_nxt;

    function automatic logic clocks_on(input state_t s);
        return (s == S_RST_HOLD) || (s == S_RUN) || (s == S_STEP);
    endfunction

    always_comb begin
        nxt        = cur;
        div_nxt    = '0;
        hold_nxt   = hold_cnt;
        step_nxt   = step_cnt;
        addr_nxt   = load_addr;
        pend_nxt   = rst_pending;
        target_nxt = target_step;
        halt_nxt   = halt_req;
        halt_now   = 1'b0;
        we_nxt     = 1'b0;
        err_nxt    = 1'b0;
        cmd_ready  = 1'b0;
        load_ready = 1'b0;

        if (clocks_on(cur)) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end

        case (cur)
            S_HALT: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            nxt      = S_LOAD;
                            addr_nxt = '0;
                            pend_nxt = 1'b1;
                        end
                        OP_RUN, OP_STEP: begin
                            target_nxt = (cmd_op == OP_STEP);
                            hold_nxt   = '0;
                            step_nxt   = '0;
                            halt_nxt   = 1'b0;
                            if (rst_pending) begin
                                nxt = S_RST_HOLD;
                            end else begin
                                nxt = (cmd_op == OP_STEP) ? S_STEP : S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    we_nxt = 1'b1;
                    // Leaving on the top address keeps the write address from wrapping.
                    if (load_last || (load_addr == ADDR_LAST)) begin
                        nxt = S_HALT;
                    end else begin
                        addr_nxt = load_addr + 1'b1;
                    end
                end
            end
            S_RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    pend_nxt = 1'b0;
                    nxt      = target_step ? S_STEP : S_RUN;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            S_RUN: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_op == OP_HALT) begin
                        halt_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                halt_now = halt_req || (cmd_valid && (cmd_op == OP_HALT));
                if (halt_now && (div_cnt == DIV_LAST)) begin
                    nxt      = S_HALT;
                    halt_nxt = 1'b0;
                end
            end
            S_STEP: begin
                // The period holding the final clken_2 is always run to its end.
                if ((step_cnt == STEP_DONE) && (div_cnt == DIV_LAST)) begin
                    nxt = S_HALT;
                end else if (div_cnt == DIV_HALF) begin
                    step_nxt = step_cnt + 1'b1;
                end
            end
            default: begin
                nxt = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_HALT;
            div_cnt     <= '0;
            hold_cnt    <= '0;
            step_cnt    <= '0;
            load_addr   <= '0;
            rst_pending <= 1'b1;
            target_step <= 1'b0;
            halt_req    <= 1'b0;
            clken_1     <= 1'b0;
            clken_2     <= 1'b0;
            rom_we      <= 1'b0;
            rom_waddr   <= '0;
            rom_wdata   <= '0;
            cmd_err     <= 1'b0;
        end else begin
            cur         <= nxt;
            div_cnt     <= div_nxt;
            hold_cnt    <= hold_nxt;
            step_cnt    <= step_nxt;
            load_addr   <= addr_nxt;
            rst_pending <= pend_nxt;
            target_step <= target_nxt;
            halt_req    <= halt_nxt;
            // Enables are registered from the next divider value so they line up with div_cnt.
            clken_1     <= clocks_on(nxt) && (div_nxt == '0);
            clken_2     <= clocks_on(nxt) && (div_nxt == DIV_HALF);
            rom_we      <= we_nxt;
            cmd_err     <= err_nxt;
            if (we_nxt) begin
                rom_waddr <= load_addr;
                rom_wdata <= load_data;
            end
        end
    end

    assign cpu_rst = rst | rst_pending;
    assign state   = cur;
    assign busy    = (cur != S_HALT);

`ifdef MCS4_CYCLE_CNT_EN
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 1'b0;
            icycle_cnt <= '0;
        end else begin
            if ((cur == S_RST_HOLD) && (nxt != S_RST_HOLD)) begin
                icycle_cnt <= '0;
            end else if (clken_1 && ((cur == S_RUN) || (cur == S_STEP)) && sync && !sync_q
                         && (icycle_cnt != 32'hFFFF_FFFF)) begin
                icycle_cnt <= icycle_cnt + 32'd1;
            end
            if (clken_1) begin
                sync_q <= sync;
            end
        end
    end
`else
    logic unused_sync;
    assign unused_sync = sync;
`endif

endmodule

// File: tb/tb_mcs4_run_ctrl.sv
// Self-checking bench for mcs4_run_ctrl: vector table, directed corner sequences and
// randomized halt/run/step/load traffic checked against an enable-stream model.
module tb_mcs4_run_ctrl;
    localparam int CLK_DIV     = 8;
    localparam int ROM_ADDR_W  = 8;
    localparam int RST_CYCLES  = 16;
    localparam int STEP_PHASES = 8;
    localparam int HALF        = CLK_DIV / 2;

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_LOAD = 2'd3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_valid, cmd_ready, cmd_err;
    logic [1:0]            cmd_op;
    logic                  load_valid, load_ready, load_last;
    logic [7:0]            load_data;
    logic                  rom_we;
    logic [ROM_ADDR_W-1:0] rom_waddr;
    logic [7:0]            rom_wdata;
    logic                  cpu_rst, clken_1, clken_2, sync, busy;
    logic [2:0]            state;

    mcs4_run_ctrl #(
        .CLK_DIV(CLK_DIV), .ROM_ADDR_W(ROM_ADDR_W),
        .RST_CYCLES(RST_CYCLES), .STEP_PHASES(STEP_PHASES)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_err(cmd_err),
        .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
        .load_last(load_last),
        .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
        .cpu_rst(cpu_rst), .clken_1(clken_1), .clken_2(clken_2), .sync(sync),
        .state(state), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit model_pend = 1'b1;

    typedef struct {
        logic       cv;
        logic [1:0] op;
        logic       lv;
        logic [7:0] ld;
        logic       ll;
        logic [2:0] st;
        logic       crdy;
        logic       lrdy;
        logic       we;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       crst;
        logic       bsy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        cmd_valid  = 1'b0;
        cmd_op     = OP_HALT;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_last  = 1'b0;
    endtask

    // Enables form one continuous stream of whole CLK_DIV periods from the command edge.
    task automatic exec_run(input int extra, input logic [1:0] bad1, input logic [1:0] bad2);
        int  base, j1, j2, h, len, exp_len, errs;
        bit  done;
        base    = model_pend ? RST_CYCLES : 0;
        j1      = base + extra;
        j2      = j1 + 2;
        h       = j2 + 2 + (extra % 3);
        exp_len = (h / CLK_DIV + 1) * CLK_DIV;
        len = 0; errs = 0; done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_RUN;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!busy) begin
                done = 1'b1;
            end else begin
                len++;
                if (clken_1 !== (i % CLK_DIV == 0))       errs++;
                if (clken_2 !== (i % CLK_DIV == HALF))    errs++;
                if (cpu_rst !== (i < base))               errs++;
                if (cmd_err !== (i == j1 + 1 || i == j2 + 1)) errs++;
                if (i == j1) begin cmd_valid = 1'b1; cmd_op = bad1; end
                if (i == j2) begin cmd_valid = 1'b1; cmd_op = bad2; end
                if (i == h)  begin cmd_valid = 1'b1; cmd_op = OP_HALT; end
            end
        end
        chk("run.length", len, exp_len);
        chk("run.pattern_errs", errs, 0);
        chk("run.end_state", {clken_1, clken_2, cpu_rst, state}, {2'b00, 1'b0, 3'd0});
        model_pend = 1'b0;
    endtask

    task automatic exec_step();
        int base, len, exp_len, errs, pulses, exp_pulses;
        bit done;
        base       = model_pend ? RST_CYCLES : 0;
        exp_len    = base + STEP_PHASES * CLK_DIV;
        exp_pulses = STEP_PHASES;
        for (int i = 0; i < base; i++) if (i % CLK_DIV == HALF) exp_pulses++;
        len = 0; errs = 0; pulses = 0; done = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_STEP;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (!busy) begin
                done = 1'b1;
            end else begin
                len++;
                if (clken_2 === 1'b1) pulses++;
                if (clken_1 !== (i % CLK_DIV == 0))    errs++;
                if (clken_2 !== (i % CLK_DIV == HALF)) errs++;
                if (cpu_rst !== (i < base))            errs++;
                if (cmd_ready !== 1'b0)                errs++;
            end
        end
        chk("step.length", len, exp_len);
        chk("step.clken2_pulses", pulses, exp_pulses);
        chk("step.pattern_errs", errs, 0);
        chk("step.end_state", {clken_1, clken_2, cpu_rst, state}, {2'b00, 1'b0, 3'd0});
        model_pend = 1'b0;
    endtask

    task automatic exec_load(input int n, input bit use_last, input bit gaps);
        logic [7:0] d;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("load.enter", {state, load_ready, cmd_ready, cpu_rst}, {3'd1, 1'b1, 1'b0, 1'b1});
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                idle();
                @(negedge clk);
                chk("load.gap", {rom_we, load_ready}, 2'b01);
            end
            d          = 8'($urandom);
            load_valid = 1'b1;
            load_data  = d;
            load_last  = use_last && (k == n - 1);
            @(negedge clk);
            load_valid = 1'b0;
            load_last  = 1'b0;
            chk("load.write", {rom_we, 8'(rom_waddr), rom_wdata, load_ready},
                {1'b1, 8'(k), d, (k != n - 1)});
        end
        chk("load.exit", {state, cpu_rst}, {3'd0, 1'b1});
        model_pend = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, OP_HALT, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, OP_LOAD, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};
        vecs[2] = '{1'b0, OP_HALT, 1'b1, 8'hD5, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 8'h00, 8'hD5, 1'b1, 1'b1};
        vecs[3] = '{1'b0, OP_HALT, 1'b1, 8'hB2, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 8'h01, 8'hB2, 1'b1, 1'b1};
        vecs[4] = '{1'b0, OP_HALT, 1'b0, 8'h00, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 8'h01, 8'hB2, 1'b1, 1'b1};
        vecs[5] = '{1'b0, OP_HALT, 1'b1, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h00, 1'b1, 1'b0};
        vecs[6] = '{1'b0, OP_HALT, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, OP_HALT, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h02, 8'h00, 1'b1, 1'b0};

        idle();
        sync = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.hold", {cpu_rst, clken_1, clken_2, state, cmd_ready, busy, load_ready, rom_we},
            {1'b1, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            cmd_valid  = vecs[i].cv;
            cmd_op     = vecs[i].op;
            load_valid = vecs[i].lv;
            load_data  = vecs[i].ld;
            load_last  = vecs[i].ll;
            @(negedge clk);
            chk($sformatf("vec%0d.state", i), state, vecs[i].st);
            chk($sformatf("vec%0d.ready", i), {cmd_ready, load_ready}, {vecs[i].crdy, vecs[i].lrdy});
            chk($sformatf("vec%0d.rom", i), {rom_we, 8'(rom_waddr), rom_wdata},
                {vecs[i].we, vecs[i].wa, vecs[i].wd});
            chk($sformatf("vec%0d.ctl", i), {cpu_rst, busy, clken_1, clken_2, cmd_err},
                {vecs[i].crst, vecs[i].bsy, 3'b000});
        end
        idle();
        model_pend = 1'b1;

        // Run out of reset, with a dropped RUN and a dropped LOAD before the halt.
        exec_run(3, OP_RUN, OP_LOAD);
        // Two steps back to back after the CPU has been released from reset.
        exec_step();
        exec_step();
        // Full-depth image with no load_last.
        exec_load(1 << ROM_ADDR_W, 1'b0, 1'b0);
        exec_step();

        // Asynchronous reset in the middle of a LOAD.
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            load_valid = 1'b1;
            load_data  = 8'hA5 ^ 8'(k * 8'h33);
            @(negedge clk);
        end
        load_data = 8'h3C;
        #2 rst = 1'b1;
        #1;
        chk("rst.async", {state, cpu_rst, clken_1, clken_2, rom_we, rom_waddr, rom_wdata,
                          cmd_err, load_ready, cmd_ready, busy},
            {3'd0, 1'b1, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
        idle();
        @(negedge clk);
        rst = 1'b0;
        model_pend = 1'b1;
        @(negedge clk);
        chk("rst.after", {state, cpu_rst, rom_we}, {3'd0, 1'b1, 1'b0});

        for (int it = 0; it < 24; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            repeat ($urandom_range(0, 3)) begin
                idle();
                @(negedge clk);
                chk("rand.idle", {state, busy, clken_1, clken_2}, 6'd0);
            end
            case (kind)
                0:       exec_load($urandom_range(1, 8), 1'b1, 1'b1);
                1:       exec_run($urandom_range(0, 12), 2'($urandom_range(1, 3)),
                                  2'($urandom_range(1, 3)));
                default: exec_step();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
